// File: rtl/sram_cfg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_cfg_access_ctrl
// Description : Single-access sequencer for a configurable-width SRAM macro
//               built from 32-bit rows split into four 8-bit lanes. Converts
//               a 32/16/8-bit logical word request into row, lane mask,
//               replicated write data and lane-extracted read data, and
//               drives the precharge / access / capture timing.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_cfg_access_ctrl #(
    parameter int ROW_W      = 6,
    parameter int PRE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_conf,
    output logic [1:0]         conf_q,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ROW_W+1:0]   req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [31:0]        resp_rdata,
    output logic               sram_pre,
    output logic               sram_en,
    output logic               sram_we,
    output logic [ROW_W-1:0]   sram_row,
    output logic [3:0]         sram_mask,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] ACC  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] MODE32 = 2'b00;
    localparam logic [1:0] MODE16 = 2'b01;
    localparam logic [1:0] MODE8  = 2'b10;

    // Counter reloads with PRE_CYCLES-1 so PRE lasts exactly PRE_CYCLES cycles
    localparam logic [1:0] PRE_LOAD = 2'(PRE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       pre_cnt_q;
    logic             we_q;
    logic             err_q;
    logic [1:0]       mode_q;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       sub_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             pend_valid_q;
    logic [1:0]       pend_conf_q;

    logic             accept;
    logic [ROW_W-1:0] dec_row;
    logic [1:0]       dec_sub;
    logic             dec_err;
    logic [31:0]      cap_data;
    logic [3:0]       acc_mask;
    logic [31:0]      acc_wdata;

    assign accept = (state_q == IDLE) && req_valid;

    // Split the logical address into row / sub-word select under the current mode
    always_comb begin
        dec_row = '0;
        dec_sub = 2'b00;
        dec_err = 1'b0;
        case (conf_q)
            MODE32: begin
                dec_row = req_addr[ROW_W-1:0];
                dec_err = |req_addr[ROW_W+1:ROW_W];
            end
            MODE16: begin
                dec_row = req_addr[ROW_W:1];
                dec_sub = {1'b0, req_addr[0]};
                dec_err = req_addr[ROW_W+1];
            end
            MODE8: begin
                dec_row = req_addr[ROW_W+1:2];
                dec_sub = req_addr[1:0];
            end
            default: dec_err = 1'b1;
        endcase
    end

    // Next-state sequencing; errors skip the macro entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = dec_err ? RESP : PRE;
            PRE:  if (pre_cnt_q == 2'd0) state_d = ACC;
            ACC:  state_d = we_q ? RESP : CAP;
            CAP:  state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and precharge down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_cnt_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pre_cnt_q <= PRE_LOAD;
            end else if (state_q == PRE && pre_cnt_q != 2'd0) begin
                pre_cnt_q <= pre_cnt_q - 2'd1;
            end
        end
    end

    // Latch the request together with the mode it was accepted under
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= MODE32;
            row_q   <= '0;
            sub_q   <= 2'b00;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= dec_err;
            mode_q  <= conf_q;
            row_q   <= dec_row;
            sub_q   <= dec_sub;
            wdata_q <= req_wdata;
        end
    end

    // Extract the addressed lane(s) from the macro read word, zero-extended
    always_comb begin
        cap_data = 32'd0;
        case (mode_q)
            MODE32: cap_data = sram_rdata;
            MODE16: cap_data = sub_q[0] ? {16'd0, sram_rdata[31:16]}
                                        : {16'd0, sram_rdata[15:0]};
            MODE8: begin
                case (sub_q)
                    2'd0:    cap_data = {24'd0, sram_rdata[7:0]};
                    2'd1:    cap_data = {24'd0, sram_rdata[15:8]};
                    2'd2:    cap_data = {24'd0, sram_rdata[23:16]};
                    default: cap_data = {24'd0, sram_rdata[31:24]};
                endcase
            end
            default: cap_data = 32'd0;
        endcase
    end

    // Read data is cleared on accept so writes and errors respond with zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (accept) begin
            rdata_q <= 32'd0;
        end else if (state_q == CAP) begin
            rdata_q <= cap_data;
        end
    end

    // Width-mode register with a one-entry pending slot applied on IDLE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_q       <= MODE32;
            pend_valid_q <= 1'b0;
            pend_conf_q  <= 2'b00;
        end else if (state_q == RESP) begin
            // The RESP->IDLE edge is where pending writes land; a write on
            // this very edge is the most recent one and wins.
            if (cfg_we) begin
                conf_q <= cfg_conf;
            end else if (pend_valid_q) begin
                conf_q <= pend_conf_q;
            end
            pend_valid_q <= 1'b0;
        end else if (cfg_we) begin
            if (state_q == IDLE && !accept) begin
                conf_q <= cfg_conf;
            end else begin
                pend_valid_q <= 1'b1;
                pend_conf_q  <= cfg_conf;
            end
        end
    end

    // Lane mask and lane-replicated write data for the latched mode
    always_comb begin
        acc_mask  = 4'b0000;
        acc_wdata = 32'd0;
        case (mode_q)
            MODE32: begin
                acc_mask  = 4'b1111;
                acc_wdata = wdata_q;
            end
            MODE16: begin
                acc_mask  = sub_q[0] ? 4'b1100 : 4'b0011;
                acc_wdata = {wdata_q[15:0], wdata_q[15:0]};
            end
            MODE8: begin
                acc_mask  = 4'b0001 << sub_q;
                acc_wdata = {4{wdata_q[7:0]}};
            end
            default: begin
                acc_mask  = 4'b0000;
                acc_wdata = 32'd0;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them immediately
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
        sram_pre   = (state_q == PRE);
        sram_en    = (state_q == ACC);
        sram_we    = (state_q == ACC) && we_q;
        sram_row   = (state_q == ACC) ? row_q : '0;
        sram_mask  = (state_q == ACC) ? acc_mask : 4'b0000;
        sram_wdata = (state_q == ACC) ? acc_wdata : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_cfg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_cfg_access_ctrl
// Description : Directed self-checking bench for sram_cfg_access_ctrl, with
//               one instance at PRE_CYCLES=1 and one at PRE_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_cfg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_conf = 2'b00;
    logic        v1 = 1'b0;
    logic        v3 = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] sram_rdata = 32'd0;

    logic [1:0]  conf1, conf3;
    logic        rdy1, rdy3, rv1, rv3, re1, re3;
    logic [31:0] rd1, rd3;
    logic        pre1, pre3, en1, en3, swe1, swe3;
    logic [5:0]  row1, row3;
    logic [3:0]  msk1, msk3;
    logic [31:0] swd1, swd3;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent run1 transaction
    int          r_lat, r_npre, r_nen;
    logic        r_err, r_swe;
    logic [31:0] r_rd, r_swd;
    logic [5:0]  r_row;
    logic [3:0]  r_msk;

    always #5 clk = ~clk;

    sram_cfg_access_ctrl #(.ROW_W(6), .PRE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_conf(cfg_conf),
        .conf_q(conf1), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
        .resp_err(re1), .resp_rdata(rd1), .sram_pre(pre1), .sram_en(en1),
        .sram_we(swe1), .sram_row(row1), .sram_mask(msk1),
        .sram_wdata(swd1), .sram_rdata(sram_rdata)
    );

    sram_cfg_access_ctrl #(.ROW_W(6), .PRE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_conf(cfg_conf),
        .conf_q(conf3), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
        .resp_err(re3), .resp_rdata(rd3), .sram_pre(pre3), .sram_en(en3),
        .sram_we(swe3), .sram_row(row3), .sram_mask(msk3),
        .sram_wdata(swd3), .sram_rdata(sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_conf = m;
        @(negedge clk);
        cfg_we = 1'b0;
        check("conf_set", {30'd0, conf1}, {30'd0, m});
    endtask

    // One transaction on the PRE_CYCLES=1 instance; optional cfg pulses at
    // cycles c1/c2 after acceptance (0 = none). Cycle 1 is the first cycle
    // after the accept edge.
    task automatic run1(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input int c1, input logic [1:0] m1, input int c2, input logic [1:0] m2);
        @(negedge clk);
        req_we = we;
        req_addr = addr;
        req_wdata = wd;
        v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        r_lat = -1; r_npre = 0; r_nen = 0; r_err = 1'b0; r_swe = 1'b0;
        r_rd = 32'd0; r_swd = 32'd0; r_row = 6'd0; r_msk = 4'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pre1) r_npre++;
            if (en1) begin
                r_nen++;
                r_row = row1; r_msk = msk1; r_swd = swd1; r_swe = swe1;
            end
            if (rv1) begin
                r_lat = c; r_err = re1; r_rd = rd1;
                cfg_we = 1'b0;
                break;
            end
            if (c == c1) begin
                cfg_we = 1'b1; cfg_conf = m1;
            end else if (c == c2) begin
                cfg_we = 1'b1; cfg_conf = m2;
            end else begin
                cfg_we = 1'b0;
            end
        end
        cfg_we = 1'b0;
        if (r_lat < 0) check("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        // Reset state
        #12;
        check("rst_conf", {30'd0, conf1}, 32'd0);
        check("rst_ready", {31'd0, rdy1}, 32'd1);
        check("rst_outs", {rv1, pre1, en1, swe1, msk1, row1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 00 write
        set_mode(2'b00);
        run1(1'b1, 8'd5, 32'hDEADBEEF, 0, 2'b00, 0, 2'b00);
        check("m0w_lat", r_lat, 32'd3);
        check("m0w_err", {31'd0, r_err}, 32'd0);
        check("m0w_row", {26'd0, r_row}, 32'd5);
        check("m0w_mask", {28'd0, r_msk}, 32'hF);
        check("m0w_wdata", r_swd, 32'hDEADBEEF);
        check("m0w_we", {31'd0, r_swe}, 32'd1);
        check("m0w_pre", r_npre, 32'd1);
        check("m0w_en", r_nen, 32'd1);

        // Mode 01 write and read
        set_mode(2'b01);
        run1(1'b1, 8'h0B, 32'h00001234, 0, 2'b00, 0, 2'b00);
        check("m1w_row", {26'd0, r_row}, 32'd5);
        check("m1w_mask", {28'd0, r_msk}, 32'hC);
        check("m1w_wdata", r_swd, 32'h12341234);
        check("m1w_rdata", r_rd, 32'd0);
        sram_rdata = 32'hABCD5678;
        run1(1'b0, 8'h0B, 32'd0, 0, 2'b00, 0, 2'b00);
        check("m1r_lat", r_lat, 32'd4);
        check("m1r_we", {31'd0, r_swe}, 32'd0);
        check("m1r_rdata", r_rd, 32'h0000ABCD);
        run1(1'b0, 8'h0A, 32'd0, 0, 2'b00, 0, 2'b00);
        check("m1r0_mask", {28'd0, r_msk}, 32'h3);
        check("m1r0_rdata", r_rd, 32'h00005678);

        // Mode 10 reads of all four lanes, then a byte write
        set_mode(2'b10);
        sram_rdata = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            run1(1'b0, 8'h14 + 8'(i), 32'd0, 0, 2'b00, 0, 2'b00);
            check("m2r_row", {26'd0, r_row}, 32'd5);
            check("m2r_mask", {28'd0, r_msk}, 32'd1 << i);
            check("m2r_rdata", r_rd, 32'h11 * (i + 1));
        end
        run1(1'b1, 8'h15, 32'h000000A5, 0, 2'b00, 0, 2'b00);
        check("m2w_mask", {28'd0, r_msk}, 32'h2);
        check("m2w_wdata", r_swd, 32'hA5A5A5A5);

        // Error cases: out of range in mode 00, anything in mode 11
        set_mode(2'b00);
        run1(1'b1, 8'h40, 32'h1, 0, 2'b00, 0, 2'b00);
        check("e0_lat", r_lat, 32'd1);
        check("e0_err", {31'd0, r_err}, 32'd1);
        check("e0_act", r_npre + r_nen, 32'd0);
        set_mode(2'b11);
        sram_rdata = 32'hFFFFFFFF;
        run1(1'b0, 8'h05, 32'd0, 0, 2'b00, 0, 2'b00);
        check("e3_lat", r_lat, 32'd1);
        check("e3_err", {31'd0, r_err}, 32'd1);
        check("e3_rdata", r_rd, 32'd0);
        check("e3_act", r_npre + r_nen, 32'd0);

        // Config write while busy is deferred until IDLE
        set_mode(2'b00);
        run1(1'b1, 8'd3, 32'h0, 1, 2'b10, 0, 2'b00);
        check("cfgp_mask", {28'd0, r_msk}, 32'hF);
        check("cfgp_hold", {30'd0, conf1}, 32'd0);
        @(negedge clk);
        check("cfgp_apply", {30'd0, conf1}, 32'd2);
        set_mode(2'b00);
        run1(1'b1, 8'd3, 32'h0, 1, 2'b01, 2, 2'b10);
        @(negedge clk);
        check("cfgp_last", {30'd0, conf1}, 32'd2);

        // PRE_CYCLES=3 instance: precharge length and write latency
        set_mode(2'b00);
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'd7; req_wdata = 32'h55;
        v3 = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        cnt = 0;
        r_lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pre3) cnt++;
            if (rv3) begin
                r_lat = c;
                break;
            end
        end
        check("p3_pre", cnt, 32'd3);
        check("p3_lat", r_lat, 32'd5);

        // Reset during ACC: abandon access with no response
        set_mode(2'b10);
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'd0; req_wdata = 32'h77;
        v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (en1) break;
            cnt++;
        end
        check("rstacc_reach", {31'd0, en1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstacc_outs", {en1, swe1, pre1, rv1, msk1, row1}, 32'd0);
        check("rstacc_wdata", swd1, 32'd0);
        check("rstacc_conf", {30'd0, conf1}, 32'd0);
        check("rstacc_ready", {31'd0, rdy1}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv1) cnt++;
        end
        check("rstacc_noresp", cnt, 32'd0);
        check("rstacc_ready2", {31'd0, rdy1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_cfg_access_ctrl.md
Name: sram_cfg_access_ctrl

Overview:
- Sequences single accesses to one configurable-width SRAM macro built from 32-bit rows.
- Each row is split into four 8-bit lanes.
- A software-set width mode selects 32-, 16- or 8-bit logical words.
- The block converts a narrow-word request into row address, lane write mask, replicated write data and lane-extracted read data, and drives the precharge/access/capture timing.

Parameters:
- ROW_W, 6: SRAM row address width (2**ROW_W rows).
- PRE_CYCLES, 1: precharge cycles per access. Legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write-enable for the width-mode register.
- cfg_conf  in  2  new mode: 00=32b, 01=16b, 10=8b, 11=reserved.
- conf_q  out  2  current applied mode.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ROW_W+2  logical word address in the current mode.
- req_wdata  in  32  write data, right-aligned to the word width.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; request was rejected.
- resp_rdata  out  32  read data, zero-extended; 0 for writes and errors.
- sram_pre  out  1  bitline precharge.
- sram_en  out  1  wordline/access enable.
- sram_we  out  1  write strobe, valid with sram_en.
- sram_row  out  ROW_W  row address.
- sram_mask  out  4  lane enable; bit0 = bits[7:0].
- sram_wdata  out  32  lane-replicated write data.
- sram_rdata  in  32  macro read data, valid during CAPTURE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State returns to IDLE; conf_q=00; pending config cleared.
  - All outputs 0 except req_ready=1.
  - An access in flight when reset asserts is abandoned with no response.
- States: IDLE, PRE, ACC, CAP, RESP.
- IDLE:
  - req_ready=1. Acceptance occurs on the edge with req_valid && req_ready.
  - The request (we, addr, wdata) and the current conf_q are latched at acceptance.
- Address decode, with sub = lane/half select:
  - Mode 00: row=addr[ROW_W-1:0]; error if addr[ROW_W+1:ROW_W]!=0.
  - Mode 01: row=addr[ROW_W:1], sub=addr[0]; error if addr[ROW_W+1]!=0.
  - Mode 10: row=addr[ROW_W+1:2], sub=addr[1:0].
  - Mode 11: always error.
- Error request: IDLE -> RESP directly.
  - No sram_pre/sram_en activity.
  - resp_valid=1, resp_err=1, resp_rdata=0.
- Legal request: IDLE -> PRE.
  - PRE: sram_pre=1 for exactly PRE_CYCLES cycles, timed by a down-counter. Then ACC.
- ACC: one cycle with sram_en=1, sram_we=req_we, and sram_row/sram_mask/sram_wdata valid.
  - Mode 00: mask=1111.
  - Mode 01: mask=0011 (sub 0) or 1100 (sub 1).
  - Mode 10: mask = one-hot lane at sub.
  - wdata replication: mode 00 passes wdata unchanged; mode 01 = {wdata[15:0], wdata[15:0]}; mode 10 = wdata[7:0] repeated x4.
  - Write: ACC -> RESP. Read: ACC -> CAP.
- CAP: sram_en=0; sram_rdata is sampled at the end of the cycle and the lane extracted:
  - Mode 00: full word.
  - Mode 01: bits[16*sub+15 : 16*sub].
  - Mode 10: bits[8*sub+7 : 8*sub].
  - Extracted data is zero-extended.
  - Then RESP.
- RESP:
  - resp_valid=1 for one cycle; resp_err=0 for legal requests; req_ready=0.
  - No response backpressure; next state IDLE.
- Latency, accept edge to resp_valid cycle, with P=PRE_CYCLES: write = P+2 cycles; read = P+3 cycles; error = 1 cycle.
- Throughput: a new request is accepted no earlier than the cycle after RESP.
- sram_row, sram_mask and sram_wdata are 0 outside ACC.
- Config:
  - cfg_we in IDLE with no acceptance on that edge: conf_q updates next edge.
  - cfg_we on an acceptance edge, or while not in IDLE: value held in a one-entry pending register (last write wins) and applied on the edge entering IDLE. The in-flight access uses the old mode.
  - Writing 11 is stored; subsequent requests receive errors.

Test Plan:
- Reset then mode 00, PRE_CYCLES=1: write addr 5, wdata 0xDEADBEEF -> sram_en in ACC with row=5, mask=1111, wdata=0xDEADBEEF; resp_valid 3 cycles after accept, resp_err=0.
- Mode 01, write addr 0x0B, data 0x1234 -> row=5, mask=1100, sram_wdata=0x12341234. Read addr 0x0B with sram_rdata=0xABCD5678 -> resp_rdata=0x0000ABCD, 4 cycles after accept.
- Mode 10, reads addr 0x14..0x17 with sram_rdata=0x44332211 -> row=5, masks 0001/0010/0100/1000, resp_rdata=0x11/0x22/0x33/0x44.
- Mode 00, addr 0x40 (ROW_W=6), and mode 11 with any addr -> resp_err=1 one cycle after accept; sram_pre and sram_en never asserted.
- cfg_we=10 during PRE of a mode-00 write -> access uses mask 1111; conf_q=10 upon IDLE. Back-to-back cfg_we 01 then 10 while busy -> conf_q=10.
- PRE_CYCLES=3: sram_pre high exactly 3 cycles. rst_n pulsed low during ACC -> outputs 0 immediately, conf_q=00, no resp_valid, req_ready=1 after release.
